addr_dec_resp_mux_mot: RTL and testbench

Per-master address decoder and response mux for the TCDM variable-latency crossbar, supporting up to `MaxOutstanding` in-flight transactions per master. It sits between one master port and `NumOut` bank ports. Responses are returned in order by allowing pipelined requests only to the bank that is already being served. A request to a different bank is held until every outstanding response has drained.

---
 rtl/addr_dec_resp_mux_mot.sv | 191 +++++++++++++++++++
 tb/tb_addr_dec_resp_mux_mot.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_dec_resp_mux_mot.sv
// ---------------------------------------------------------------------------
// addr_dec_resp_mux_mot
//
// Per-master address decoder and response mux for the TCDM variable-latency
// crossbar. One master port fans out to NumOut bank ports, and up to
// MaxOutstanding transactions may be in flight at once.
//
// Responses are kept in order by a simple rule. Pipelined requests may go
// only to the bank that is already being served. A request to any other bank
// waits until every outstanding response has drained. It may issue in the
// same cycle as the last response retires.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   req_i          master request
//   add_i          bank index (ignored when NumOut == 1)
//   wen_i          write enable, carried in the request payload
//   data_i         request payload
//   gnt_o          grant to master
//   vld_o          response valid to master
//   rdata_o        response data to master
//   outstanding_o  current number of in-flight transactions
//   req_o          one-hot request to the banks
//   gnt_i          grants from the banks
//   vld_i          response valids from the banks
//   data_o         data_i replicated to every bank
//   rdata_i        response data from the banks
// ---------------------------------------------------------------------------
module addr_dec_resp_mux_mot #(
    parameter int unsigned NumOut         = 32,
    parameter int unsigned ReqDataWidth   = 32,
    parameter int unsigned RespDataWidth  = 32,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned AddrWidth     = (NumOut > 1) ? $clog2(NumOut) : 1,
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    // master side
    input  logic                                   req_i,
    input  logic [AddrWidth-1:0]                   add_i,
    input  logic                                   wen_i,
    input  logic [ReqDataWidth-1:0]                data_i,
    output logic                                   gnt_o,
    output logic                                   vld_o,
    output logic [RespDataWidth-1:0]               rdata_o,
    output logic [CntWidth-1:0]                    outstanding_o,
    // bank side
    output logic [NumOut-1:0]                      req_o,
    input  logic [NumOut-1:0]                      gnt_i,
    input  logic [NumOut-1:0]                      vld_i,
    output logic [NumOut-1:0][ReqDataWidth-1:0]    data_o,
    input  logic [NumOut-1:0][RespDataWidth-1:0]   rdata_i
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [AddrWidth-1:0] bank_sel_q, bank_sel_d;

    // -----------------------------------------------------------------------
    // Effective bank index. With a single bank the address is meaningless.
    // It is forced to zero, so the same-bank check always holds.
    // -----------------------------------------------------------------------
    logic [AddrWidth-1:0] bank_idx;

    generate
        if (NumOut == 1) begin : g_single_bank
            logic unused_add;
            assign unused_add = ^add_i;
            assign bank_idx   = '0;
        end else begin : g_multi_bank
            assign bank_idx = add_i;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // One-hot decodes. The target decode and the served-bank decode are built
    // as masks. gnt_i, vld_i and rdata_i are then selected by AND-OR rather
    // than by indexing. With a non-power-of-two NumOut, an out-of-range
    // add_i decodes to all zeros and is never forwarded.
    // -----------------------------------------------------------------------
    logic [NumOut-1:0]                    dec_onehot;
    logic [NumOut-1:0]                    sel_onehot;
    logic [NumOut-1:0][RespDataWidth-1:0] rdata_masked;

    generate
        for (genvar gi = 0; gi < NumOut; gi++) begin : g_bank
            assign dec_onehot[gi]   = (bank_idx == AddrWidth'(gi));
            assign sel_onehot[gi]   = (bank_sel_q == AddrWidth'(gi));
            assign rdata_masked[gi] = rdata_i[gi] & {RespDataWidth{sel_onehot[gi]}};
            // Payload broadcast: every bank sees the same request data.
            assign data_o[gi]       = data_i;
        end
    endgenerate

    logic                     add_ok;
    logic                     sel_vld;
    logic [RespDataWidth-1:0] sel_rdata;

    assign add_ok  = |dec_onehot;
    assign sel_vld = |(vld_i & sel_onehot);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NumOut; i++) begin
            sel_rdata = sel_rdata | rdata_masked[i];
        end
    end

    // wen_i only travels inside the payload the master already packed into
    // data_i. It has no effect on routing or ordering.
    logic unused_wen;
    assign unused_wen = wen_i;

    // -----------------------------------------------------------------------
    // Response side
    // A valid from the served bank counts only while something is in flight.
    // Valids from other banks, or valids while idle, are dropped.
    // -----------------------------------------------------------------------
    logic cnt_zero;
    logic cnt_one;
    logic cnt_below_max;
    logic retire;

    assign cnt_zero      = (cnt_q == '0);
    assign cnt_one       = (cnt_q == CntWidth'(1));
    assign cnt_below_max = (cnt_q < CntWidth'(MaxOutstanding));

    assign vld_o   = ~cnt_zero & sel_vld;
    assign rdata_o = sel_rdata;
    assign retire  = vld_o;

    // -----------------------------------------------------------------------
    // Request side
    // A request is forwarded when one of these holds:
    //   - idle: any bank;
    //   - same bank as in flight, with room or with a slot freed this cycle;
    //   - exactly one response left and it retires now: any bank, because
    //     ordering cannot be violated once the pipe is empty.
    // The retire terms give a combinational path from vld_i to req_o.
    // -----------------------------------------------------------------------
    logic same_bank;
    logic fwd;
    logic acc;

    assign same_bank = (bank_idx == bank_sel_q);

    assign fwd = req_i & add_ok &
                 (cnt_zero |
                  (same_bank & (cnt_below_max | retire)) |
                  (cnt_one & retire));

    assign req_o = fwd ? dec_onehot : '0;
    assign gnt_o = fwd & |(gnt_i & dec_onehot);
    assign acc   = req_i & gnt_o;

    // -----------------------------------------------------------------------
    // Next-state logic
    // An accept and a retire in the same cycle cancel out. fwd already keeps
    // an accept from pushing the count past MaxOutstanding. retire needs a
    // non-zero count, so the counter cannot underflow.
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d      = cnt_q;
        bank_sel_d = bank_sel_q;
        if (acc && !retire) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (!acc && retire) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
        if (acc) begin
            bank_sel_d = bank_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            bank_sel_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            bank_sel_q <= bank_sel_d;
        end
    end

    assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_addr_dec_resp_mux_mot.sv
// ---------------------------------------------------------------------------
// Testbench for addr_dec_resp_mux_mot.
// Main instance: NumOut=4, MaxOutstanding=4, 32-bit data.
// Second instance: NumOut=1, MaxOutstanding=1, 8-bit data (degenerate case).
// Inputs are driven on the falling edge. Outputs are sampled 1 ns later, so
// the count seen is the value before the next rising edge.
// ---------------------------------------------------------------------------
module tb_addr_dec_resp_mux_mot;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ni;

    // ---------------- main DUT (4 banks, 4 outstanding) ----------------
    logic              req_i;
    logic [1:0]        add_i;
    logic              wen_i;
    logic [31:0]       data_i;
    logic              gnt_o;
    logic              vld_o;
    logic [31:0]       rdata_o;
    logic [2:0]        outstanding_o;
    logic [3:0]        req_o;
    logic [3:0]        gnt_i;
    logic [3:0]        vld_i;
    logic [3:0][31:0]  data_o;
    logic [3:0][31:0]  rdata_i;

    addr_dec_resp_mux_mot #(
        .NumOut         (4),
        .ReqDataWidth   (32),
        .RespDataWidth  (32),
        .MaxOutstanding (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .add_i         (add_i),
        .wen_i         (wen_i),
        .data_i        (data_i),
        .gnt_o         (gnt_o),
        .vld_o         (vld_o),
        .rdata_o       (rdata_o),
        .outstanding_o (outstanding_o),
        .req_o         (req_o),
        .gnt_i         (gnt_i),
        .vld_i         (vld_i),
        .data_o        (data_o),
        .rdata_i       (rdata_i)
    );

    // ---------------- degenerate DUT (1 bank, 1 outstanding) ----------------
    logic             s_req;
    logic [0:0]       s_add;
    logic             s_wen;
    logic [7:0]       s_data;
    logic             s_gnt_o;
    logic             s_vld_o;
    logic [7:0]       s_rdata_o;
    logic [0:0]       s_out;
    logic [0:0]       s_req_o;
    logic [0:0]       s_gnt;
    logic [0:0]       s_vld;
    logic [0:0][7:0]  s_data_o;
    logic [0:0][7:0]  s_rdata;

    addr_dec_resp_mux_mot #(
        .NumOut         (1),
        .ReqDataWidth   (8),
        .RespDataWidth  (8),
        .MaxOutstanding (1)
    ) dut_single (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_i         (s_req),
        .add_i         (s_add),
        .wen_i         (s_wen),
        .data_i        (s_data),
        .gnt_o         (s_gnt_o),
        .vld_o         (s_vld_o),
        .rdata_o       (s_rdata_o),
        .outstanding_o (s_out),
        .req_o         (s_req_o),
        .gnt_i         (s_gnt),
        .vld_i         (s_vld),
        .data_o        (s_data_o),
        .rdata_i       (s_rdata)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        req;
        logic [1:0]  add;
        logic [3:0]  gnt;
        logic [3:0]  vld;
        int          rbank;    // bank carrying rdata; all others carry filler
        logic [31:0] rdata;
        logic [3:0]  e_req;
        logic        e_gnt;
        logic        e_vld;
        logic [31:0] e_rdata;  // checked only when e_vld
        logic [2:0]  e_cnt;    // outstanding_o before the next rising edge
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic [1:0] a, input logic [3:0] g,
                                input logic [3:0] v, input int rb, input logic [31:0] rd,
                                input logic [3:0] er, input logic eg, input logic ev,
                                input logic [31:0] erd, input logic [2:0] ec);
        vec_t t;
        t.req = r; t.add = a; t.gnt = g; t.vld = v; t.rbank = rb; t.rdata = rd;
        t.e_req = er; t.e_gnt = eg; t.e_vld = ev; t.e_rdata = erd; t.e_cnt = ec;
        return t;
    endfunction

    initial begin
        rst_ni = 1'b0;
        req_i = 1'b0; add_i = '0; wen_i = 1'b0; data_i = '0;
        gnt_i = '0; vld_i = '0; rdata_i = '0;
        s_req = 1'b0; s_add = '0; s_wen = 1'b0; s_data = '0; s_gnt = '0; s_vld = '0; s_rdata = '0;

        //          req add  gnt      vld      rb rdata  | e_req   eg ev e_rdata cnt
        // idle single read to bank 2
        vq.push_back(mk(1, 2, 4'b0100, 4'b0000, 0, 32'h0,  4'b0100, 1, 0, 32'h0,  3'd0));
        vq.push_back(mk(0, 0, 4'b0000, 4'b0100, 2, 32'hA5, 4'b0000, 0, 1, 32'hA5, 3'd1));
        vq.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 32'h0,  4'b0000, 0, 0, 32'h0,  3'd0));
        // spurious response while idle
        vq.push_back(mk(0, 0, 4'b0000, 4'b0010, 1, 32'h77, 4'b0000, 0, 0, 32'h0,  3'd0));
        vq.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 32'h0,  4'b0000, 0, 0, 32'h0,  3'd0));
        // pipelined burst of 6 to bank 1, no responses
        vq.push_back(mk(1, 1, 4'b0010, 4'b0000, 0, 32'h0,  4'b0010, 1, 0, 32'h0,  3'd0));
        vq.push_back(mk(1, 1, 4'b0010, 4'b0000, 0, 32'h0,  4'b0010, 1, 0, 32'h0,  3'd1));
        vq.push_back(mk(1, 1, 4'b0010, 4'b0000, 0, 32'h0,  4'b0010, 1, 0, 32'h0,  3'd2));
        vq.push_back(mk(1, 1, 4'b0010, 4'b0000, 0, 32'h0,  4'b0010, 1, 0, 32'h0,  3'd3));
        vq.push_back(mk(1, 1, 4'b0010, 4'b0000, 0, 32'h0,  4'b0000, 0, 0, 32'h0,  3'd4));
        vq.push_back(mk(1, 1, 4'b0010, 4'b0000, 0, 32'h0,  4'b0000, 0, 0, 32'h0,  3'd4));
        // a retire frees a slot: the 5th request goes out in the same cycle
        vq.push_back(mk(1, 1, 4'b0010, 4'b0010, 1, 32'h11, 4'b0010, 1, 1, 32'h11, 3'd4));
        vq.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 32'h0,  4'b0000, 0, 0, 32'h0,  3'd4));
        // drain four responses
        vq.push_back(mk(0, 0, 4'b0000, 4'b0010, 1, 32'h12, 4'b0000, 0, 1, 32'h12, 3'd4));
        vq.push_back(mk(0, 0, 4'b0000, 4'b0010, 1, 32'h13, 4'b0000, 0, 1, 32'h13, 3'd3));
        vq.push_back(mk(0, 0, 4'b0000, 4'b0010, 1, 32'h14, 4'b0000, 0, 1, 32'h14, 3'd2));
        vq.push_back(mk(0, 0, 4'b0000, 4'b0010, 1, 32'h15, 4'b0000, 0, 1, 32'h15, 3'd1));
        vq.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 32'h0,  4'b0000, 0, 0, 32'h0,  3'd0));
        // bank switch: two to bank 0, then bank 3 stalls until the last retire
        vq.push_back(mk(1, 0, 4'b1001, 4'b0000, 0, 32'h0,  4'b0001, 1, 0, 32'h0,  3'd0));
        vq.push_back(mk(1, 0, 4'b1001, 4'b0000, 0, 32'h0,  4'b0001, 1, 0, 32'h0,  3'd1));
        vq.push_back(mk(1, 3, 4'b1001, 4'b0000, 0, 32'h0,  4'b0000, 0, 0, 32'h0,  3'd2));
        vq.push_back(mk(1, 3, 4'b1001, 4'b0001, 0, 32'h22, 4'b0000, 0, 1, 32'h22, 3'd2));
        vq.push_back(mk(1, 3, 4'b1001, 4'b0001, 0, 32'h33, 4'b1000, 1, 1, 32'h33, 3'd1));
        // one outstanding on bank 3; a valid from bank 0 is ignored
        vq.push_back(mk(0, 0, 4'b0000, 4'b0001, 0, 32'h99, 4'b0000, 0, 0, 32'h0,  3'd1));
        vq.push_back(mk(0, 0, 4'b0000, 4'b1000, 3, 32'h44, 4'b0000, 0, 1, 32'h44, 3'd1));
        vq.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 32'h0,  4'b0000, 0, 0, 32'h0,  3'd0));
        // bank 2 denies the grant: request visible, count unchanged
        vq.push_back(mk(1, 2, 4'b1011, 4'b0000, 0, 32'h0,  4'b0100, 0, 0, 32'h0,  3'd0));
        vq.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 32'h0,  4'b0000, 0, 0, 32'h0,  3'd0));

        // ---------------- reset state ----------------
        @(negedge clk);
        #1;
        chk("reset_outstanding", 32'(outstanding_o), 32'd0);
        chk("reset_req_o",       32'(req_o),         32'd0);
        chk("reset_gnt_o",       32'(gnt_o),         32'd0);
        chk("reset_vld_o",       32'(vld_o),         32'd0);
        chk("reset_single_out",  32'(s_out),         32'd0);
        rst_ni = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            req_i  = vq[i].req;
            add_i  = vq[i].add;
            gnt_i  = vq[i].gnt;
            vld_i  = vq[i].vld;
            wen_i  = i[0];
            data_i = 32'hC0DE_0000 + 32'(i);
            for (int b = 0; b < 4; b++) begin
                rdata_i[b] = (b == vq[i].rbank) ? vq[i].rdata : (32'hDEAD_0000 | 32'(b));
            end
            #1;
            $display("vec %0d: req=%0d add=%0d gnt=%b vld=%b -> req_o=%b gnt_o=%0d vld_o=%0d rdata_o=%h cnt=%0d",
                     i, req_i, add_i, gnt_i, vld_i, req_o, gnt_o, vld_o, rdata_o, outstanding_o);
            chk($sformatf("v%0d_req_o", i), 32'(req_o),         32'(vq[i].e_req));
            chk($sformatf("v%0d_gnt_o", i), 32'(gnt_o),         32'(vq[i].e_gnt));
            chk($sformatf("v%0d_vld_o", i), 32'(vld_o),         32'(vq[i].e_vld));
            chk($sformatf("v%0d_cnt",   i), 32'(outstanding_o), 32'(vq[i].e_cnt));
            if (vq[i].e_vld) begin
                chk($sformatf("v%0d_rdata", i), rdata_o, vq[i].e_rdata);
            end
            chk($sformatf("v%0d_data_o0", i), data_o[0], data_i);
            chk($sformatf("v%0d_data_o3", i), data_o[3], data_i);
        end

        // ---------------- async reset mid-burst ----------------
        @(negedge clk);
        req_i = 1'b1; add_i = 2'd1; gnt_i = 4'b0010; vld_i = '0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        req_i = 1'b0;
        #1;
        $display("rst seq: burst of 3 -> cnt=%0d", outstanding_o);
        chk("rst_pre_cnt", 32'(outstanding_o), 32'd3);
        #2;
        rst_ni = 1'b0;
        #1;
        $display("rst seq: reset asserted mid-cycle -> cnt=%0d", outstanding_o);
        chk("rst_async_cnt", 32'(outstanding_o), 32'd0);
        vld_i = 4'b0010;
        rdata_i[1] = 32'h5555_0001;
        #1;
        $display("rst seq: late response during reset -> vld_o=%0d", vld_o);
        chk("rst_late_vld", 32'(vld_o), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_hold_cnt", 32'(outstanding_o), 32'd0);
        rst_ni = 1'b1;
        vld_i = '0;
        req_i = 1'b1; add_i = 2'd3; gnt_i = 4'b1000;
        #1;
        $display("rst seq: first request after reset -> req_o=%b gnt_o=%0d", req_o, gnt_o);
        chk("rst_after_req_o", 32'(req_o), 32'b1000);
        chk("rst_after_gnt_o", 32'(gnt_o), 32'd1);
        @(negedge clk);
        req_i = 1'b0; gnt_i = '0;
        #1;
        chk("rst_after_cnt", 32'(outstanding_o), 32'd1);

        // ---------------- degenerate: 1 bank, 1 outstanding ----------------
        @(negedge clk);
        s_req = 1'b1; s_add = 1'b1; s_gnt = 1'b1; s_data = 8'h3C;
        #1;
        $display("single: idle request -> req_o=%b gnt_o=%0d cnt=%0d", s_req_o, s_gnt_o, s_out);
        chk("s_idle_req_o", 32'(s_req_o), 32'd1);
        chk("s_idle_gnt_o", 32'(s_gnt_o), 32'd1);
        chk("s_data_o",     32'(s_data_o[0]), 32'h3C);
        @(negedge clk);
        #1;
        $display("single: second request while full -> req_o=%b gnt_o=%0d cnt=%0d", s_req_o, s_gnt_o, s_out);
        chk("s_full_cnt",   32'(s_out),   32'd1);
        chk("s_full_req_o", 32'(s_req_o), 32'd0);
        chk("s_full_gnt_o", 32'(s_gnt_o), 32'd0);
        s_vld = 1'b1; s_rdata = 8'h5A;
        #1;
        $display("single: retire enables issue -> gnt_o=%0d vld_o=%0d rdata_o=%h", s_gnt_o, s_vld_o, s_rdata_o);
        chk("s_retire_gnt_o", 32'(s_gnt_o),   32'd1);
        chk("s_retire_vld_o", 32'(s_vld_o),   32'd1);
        chk("s_retire_rdata", 32'(s_rdata_o), 32'h5A);
        @(negedge clk);
        s_req = 1'b0; s_vld = 1'b0;
        #1;
        chk("s_swap_cnt", 32'(s_out), 32'd1);
        s_vld = 1'b1; s_rdata = 8'hA7;
        #1;
        $display("single: final response -> vld_o=%0d rdata_o=%h", s_vld_o, s_rdata_o);
        chk("s_last_vld_o", 32'(s_vld_o),   32'd1);
        chk("s_last_rdata", 32'(s_rdata_o), 32'hA7);
        @(negedge clk);
        s_vld = 1'b0;
        #1;
        chk("s_drained_cnt", 32'(s_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
